// File: rtl/bcd_time_counter.sv
// bcd_time_counter
//   BCD timekeeping core (MM:SS or HH:MM:SS) with a built-in prescaler that
//   turns the system clock into count steps. Counts up or down, supports a
//   synchronous clear and a per-field validated load, and raises one-cycle
//   pulses for each step, for an alarm match and for reaching zero when
//   counting down.
//
// Ports
//   clk          system clock
//   resetn       asynchronous active-low reset
//   en           count enable (prescaler holds while low)
//   down         0 = count up, 1 = count down
//   clear        synchronous clear of time and prescaler
//   load         synchronous load of load_value (validated per field)
//   load_value   BCD value to load, field 0 = seconds in [7:0]
//   alarm_en     enables the alarm compare
//   alarm_value  BCD alarm time
//   time_out     current BCD time (registered)
//   tick         one-cycle pulse per count step
//   alarm_hit    one-cycle pulse when a step lands on alarm_value
//   zero_hit     one-cycle pulse when a down step reaches zero
module bcd_time_counter #(
  parameter int TICK_DIV  = 100_000_000,
  parameter int FIELDS    = 2,
  parameter int HOUR_WRAP = 24
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                en,
  input  logic                down,
  input  logic                clear,
  input  logic                load,
  input  logic [8*FIELDS-1:0] load_value,
  input  logic                alarm_en,
  input  logic [8*FIELDS-1:0] alarm_value,
  output logic [8*FIELDS-1:0] time_out,
  output logic                tick,
  output logic                alarm_hit,
  output logic                zero_hit
);

  localparam int W  = 8 * FIELDS;
  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

  // Modulus of field idx: the top field of an HH:MM:SS counter wraps at
  // HOUR_WRAP, every other field at 60.
  function automatic logic [7:0] field_mod(input int idx);
    if (FIELDS == 3 && idx == 2) return 8'(HOUR_WRAP);
    return 8'd60;
  endfunction

  function automatic logic [7:0] bcd2bin(input logic [7:0] b);
    return {4'd0, b[7:4]} * 8'd10 + {4'd0, b[3:0]};
  endfunction

  function automatic logic [7:0] bin2bcd(input logic [7:0] v);
    return {4'(v / 8'd10), 4'(v % 8'd10)};
  endfunction

  // A loaded field with a non-decimal digit or an out-of-range value
  // becomes 00; valid fields pass unchanged.
  function automatic logic [7:0] load_field(input logic [7:0] b,
                                            input logic [7:0] m);
    if (b[7:4] > 4'd9 || b[3:0] > 4'd9) return 8'h00;
    if (bcd2bin(b) >= m) return 8'h00;
    return b;
  endfunction

  logic [PW-1:0] presc_cnt;
  logic [W-1:0]  time_p1;
  logic          tick_p1;
  logic          alarm_hit_p1;
  logic          zero_hit_p1;

  logic [W-1:0]  inc_val;
  logic [W-1:0]  dec_val;
  logic [W-1:0]  load_val;
  logic [W-1:0]  step_val;
  logic [W-1:0]  time_nxt;
  logic          step_ok;

  // ---- stage 0: prescaler decode and next-time computation ----
  // clear/load win over a coinciding step, so a step is only taken when
  // neither is asserted.
  assign step_ok = en && (presc_cnt == PRESC_MAX) && !clear && !load;

  always_comb begin : next_time_calc
    logic       carry;
    logic       borrow;
    logic [7:0] f;
    logic [7:0] m;
    inc_val  = '0;
    dec_val  = '0;
    load_val = '0;
    carry    = 1'b1;
    borrow   = 1'b1;
    f        = '0;
    m        = '0;
    for (int i = 0; i < FIELDS; i++) begin
      m = field_mod(i);
      f = bcd2bin(time_p1[8*i +: 8]);
      // Increment with ripple carry; the final carry out is dropped so the
      // all-max value wraps to all-zero.
      if (carry) begin
        if (f + 8'd1 >= m) begin
          inc_val[8*i +: 8] = 8'h00;
        end else begin
          inc_val[8*i +: 8] = bin2bcd(f + 8'd1);
          carry = 1'b0;
        end
      end else begin
        inc_val[8*i +: 8] = time_p1[8*i +: 8];
      end
      // Decrement with ripple borrow.
      if (borrow) begin
        if (f == 8'd0) begin
          dec_val[8*i +: 8] = bin2bcd(m - 8'd1);
        end else begin
          dec_val[8*i +: 8] = bin2bcd(f - 8'd1);
          borrow = 1'b0;
        end
      end else begin
        dec_val[8*i +: 8] = time_p1[8*i +: 8];
      end
      load_val[8*i +: 8] = load_field(load_value[8*i +: 8], m);
    end
    // Counting down from zero holds rather than wrapping.
    if (time_p1 == '0) dec_val = '0;
  end

  assign step_val = down ? dec_val : inc_val;

  always_comb begin
    time_nxt = time_p1;
    if (clear)        time_nxt = '0;
    else if (load)    time_nxt = load_val;
    else if (step_ok) time_nxt = step_val;
  end

  // ---- stage 1: registered time, prescaler and event pulses ----
  // Alarm and zero detection look at the value being stepped into, so the
  // pulses line up with the cycle in which time_out shows that value.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      presc_cnt    <= '0;
      time_p1      <= '0;
      tick_p1      <= 1'b0;
      alarm_hit_p1 <= 1'b0;
      zero_hit_p1  <= 1'b0;
    end else begin
      time_p1 <= time_nxt;
      if (clear || load) begin
        presc_cnt <= '0;
      end else if (en) begin
        presc_cnt <= (presc_cnt == PRESC_MAX) ? '0 : presc_cnt + PW'(1);
      end
      tick_p1      <= step_ok;
      alarm_hit_p1 <= step_ok && alarm_en && (step_val == alarm_value);
      zero_hit_p1  <= step_ok && down && (time_p1 != '0) && (step_val == '0);
    end
  end

  assign time_out  = time_p1;
  assign tick      = tick_p1;
  assign alarm_hit = alarm_hit_p1;
  assign zero_hit  = zero_hit_p1;

endmodule

// File: tb/tb_bcd_time_counter.sv
// tb_bcd_time_counter
//   Drives an MM:SS instance and an HH:MM:SS instance of bcd_time_counter with
//   shared control inputs. A reference model tracks time as a plain count of
//   seconds and is compared against both instances every cycle, with directed
//   scenarios followed by a randomized phase.
module tb_bcd_time_counter;

  localparam int TD = 4;
  localparam int HW = 24;

  logic        clk = 1'b0;
  logic        resetn = 1'b1;
  logic        en = 1'b0;
  logic        down = 1'b0;
  logic        clear = 1'b0;
  logic        load = 1'b0;
  logic        alarm_en = 1'b0;
  logic [15:0] lv2 = '0;
  logic [15:0] av2 = '0;
  logic [23:0] lv3 = '0;
  logic [23:0] av3 = '0;
  logic [15:0] t2;
  logic [23:0] t3;
  logic        tick2, tick3, ah2, ah3, zh2, zh3;

  bcd_time_counter #(.TICK_DIV(TD), .FIELDS(2), .HOUR_WRAP(HW)) dut2 (
    .clk(clk), .resetn(resetn), .en(en), .down(down), .clear(clear),
    .load(load), .load_value(lv2), .alarm_en(alarm_en), .alarm_value(av2),
    .time_out(t2), .tick(tick2), .alarm_hit(ah2), .zero_hit(zh2));

  bcd_time_counter #(.TICK_DIV(TD), .FIELDS(3), .HOUR_WRAP(HW)) dut3 (
    .clk(clk), .resetn(resetn), .en(en), .down(down), .clear(clear),
    .load(load), .load_value(lv3), .alarm_en(alarm_en), .alarm_value(av3),
    .time_out(t3), .tick(tick3), .alarm_hit(ah3), .zero_hit(zh3));

  always #5 clk = ~clk;

  int   checks = 0;
  int   failures = 0;
  int   m_presc = 0;
  int   m_tot2 = 0;
  int   m_tot3 = 0;
  logic e_tick = 1'b0;
  logic e_ah2 = 1'b0, e_ah3 = 1'b0, e_zh2 = 1'b0, e_zh3 = 1'b0;

  task automatic chk(input string tag, input logic [23:0] act, input logic [23:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, act, exp);
    end
  endtask

  // Seconds represented by a loaded BCD word, invalid fields counting as 0.
  function automatic int load_tot(input logic [23:0] v, input int nf);
    int tot;
    int w[3];
    int md[3];
    tot = 0;
    w  = '{1, 60, 3600};
    md = '{60, 60, HW};
    for (int i = 0; i < nf; i++) begin
      int hi, lo, val;
      hi = int'(v[8*i+4 +: 4]);
      lo = int'(v[8*i +: 4]);
      if (hi <= 9 && lo <= 9) begin
        val = hi * 10 + lo;
        if (val < md[i]) tot += val * w[i];
      end
    end
    return tot;
  endfunction

  function automatic logic [23:0] to_bcd(input int tot);
    int s, m, h;
    s = tot % 60;
    m = (tot / 60) % 60;
    h = tot / 3600;
    return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  // Advance the model by one clock using the inputs currently driven, let the
  // DUTs take the same edge, then compare on the following falling edge.
  task automatic cycle();
    int n2, n3;
    e_tick = 1'b0; e_ah2 = 1'b0; e_ah3 = 1'b0; e_zh2 = 1'b0; e_zh3 = 1'b0;
    if (!resetn) begin
      m_presc = 0; m_tot2 = 0; m_tot3 = 0;
    end else if (clear) begin
      m_presc = 0; m_tot2 = 0; m_tot3 = 0;
    end else if (load) begin
      m_presc = 0;
      m_tot2 = load_tot({8'h00, lv2}, 2);
      m_tot3 = load_tot(lv3, 3);
    end else if (en) begin
      if (m_presc == TD - 1) begin
        m_presc = 0;
        e_tick = 1'b1;
        if (down) begin
          n2 = (m_tot2 > 0) ? m_tot2 - 1 : 0;
          n3 = (m_tot3 > 0) ? m_tot3 - 1 : 0;
          e_zh2 = (m_tot2 != 0) && (n2 == 0);
          e_zh3 = (m_tot3 != 0) && (n3 == 0);
        end else begin
          n2 = (m_tot2 + 1) % 3600;
          n3 = (m_tot3 + 1) % (HW * 3600);
        end
        e_ah2 = alarm_en && (to_bcd(n2) == {8'h00, av2});
        e_ah3 = alarm_en && (to_bcd(n3) == av3);
        m_tot2 = n2;
        m_tot3 = n3;
      end else begin
        m_presc++;
      end
    end
    @(posedge clk);
    @(negedge clk);
    chk("time2", {8'h00, t2}, to_bcd(m_tot2));
    chk("time3", t3, to_bcd(m_tot3));
    chk("tick2", 24'(tick2), 24'(e_tick));
    chk("tick3", 24'(tick3), 24'(e_tick));
    chk("alarm2", 24'(ah2), 24'(e_ah2));
    chk("alarm3", 24'(ah3), 24'(e_ah3));
    chk("zero2", 24'(zh2), 24'(e_zh2));
    chk("zero3", 24'(zh3), 24'(e_zh3));
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  task automatic do_load(input logic [15:0] v2, input logic [23:0] v3);
    lv2 = v2; lv3 = v3; load = 1'b1;
    cycle();
    load = 1'b0;
  endtask

  initial begin
    int cnt;
    logic [23:0] tmp;
    #2 resetn = 1'b0;
    @(negedge clk);
    chk("rst_time2", {8'h00, t2}, 24'h0);
    chk("rst_time3", t3, 24'h0);
    chk("rst_pulses", {21'd0, tick2, ah2, zh2}, 24'h0);
    run(2);
    resetn = 1'b1; en = 1'b1; down = 1'b0;
    run(3);
    chk("pre_first_tick", 24'(tick2), 24'h0);
    run(1);
    chk("first_step", {8'h00, t2}, 24'h0001);
    chk("first_tick", 24'(tick2), 24'h1);
    run(4);
    chk("second_step", {8'h00, t2}, 24'h0002);

    // Carry and wrap behaviour
    do_load(16'h0959, 24'h235959);
    run(4);
    chk("wrap_0959", {8'h00, t2}, 24'h1000);
    chk("wrap_235959", t3, 24'h000000);
    do_load(16'h5959, 24'h245959);
    chk("load_245959", t3, 24'h005959);
    run(4);
    chk("wrap_5959", {8'h00, t2}, 24'h0000);
    chk("carry_005959", t3, 24'h010000);

    // Down count to zero and hold
    down = 1'b1;
    do_load(16'h0002, 24'h000002);
    run(4);
    chk("down_0001", {8'h00, t2}, 24'h0001);
    run(4);
    chk("down_0000", {8'h00, t2}, 24'h0000);
    chk("zero_pulse", 24'(zh2), 24'h1);
    cnt = 0;
    repeat (8) begin
      cycle();
      if (zh2) cnt++;
    end
    chk("zero_hold_nopulse", 24'(cnt), 24'h0);
    chk("zero_hold_time", {8'h00, t2}, 24'h0000);

    // Alarm on a step, not on a load
    down = 1'b0; alarm_en = 1'b1; av2 = 16'h0003; av3 = 24'h000003;
    clear = 1'b1;
    cycle();
    clear = 1'b0;
    cnt = 0;
    repeat (16) begin
      cycle();
      if (ah2) cnt++;
    end
    chk("alarm_count", 24'(cnt), 24'h1);
    do_load(16'h0003, 24'h000003);
    chk("alarm_on_load", 24'(ah2), 24'h0);
    run(4);
    chk("after_load_0004", {8'h00, t2}, 24'h0004);

    // Invalid load fields and clear/load coincidence
    do_load(16'h6A12, 24'h3A6012);
    chk("invalid_load2", {8'h00, t2}, 24'h0012);
    chk("invalid_load3", t3, 24'h000012);
    clear = 1'b1; load = 1'b1; lv2 = 16'h1234; lv3 = 24'h121234;
    cycle();
    clear = 1'b0; load = 1'b0;
    chk("clear_over_load", {8'h00, t2}, 24'h0000);

    // Reset asserted mid-count
    do_load(16'h0010, 24'h000010);
    run(6);
    resetn = 1'b0;
    #1;
    chk("async_rst_time", {8'h00, t2}, 24'h0);
    chk("async_rst_time3", t3, 24'h0);
    run(1);
    resetn = 1'b1;
    run(3);
    chk("rst_release_notick", 24'(tick2), 24'h0);
    run(1);
    chk("rst_release_step", {8'h00, t2}, 24'h0001);

    // Randomized phase
    repeat (700) begin
      en    = ($urandom_range(0, 9) != 0);
      clear = ($urandom_range(0, 59) == 0);
      load  = ($urandom_range(0, 24) == 0);
      resetn = ($urandom_range(0, 199) != 0);
      if ($urandom_range(0, 19) == 0) down = ~down;
      alarm_en = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 3) == 0) begin
        lv2 = 16'($urandom);
        lv3 = 24'($urandom);
      end else begin
        tmp = to_bcd(int'($urandom_range(0, 3599)));
        lv2 = tmp[15:0];
        if ($urandom_range(0, 1) == 0) lv2 = tmp[15:0] & 16'h0007;
        lv3 = to_bcd(int'($urandom_range(0, HW * 3600 - 1)));
        if ($urandom_range(0, 1) == 0) lv3 = lv3 & 24'h000007;
      end
      if ($urandom_range(0, 7) == 0) begin
        tmp = to_bcd((m_tot2 + int'($urandom_range(1, 3))) % 3600);
        av2 = tmp[15:0];
        av3 = to_bcd((m_tot3 + int'($urandom_range(1, 3))) % (HW * 3600));
      end
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bcd_time_counter.md
# bcd_time_counter

Parametrised BCD timekeeping core for the alarm-clock design, replacing the fixed MM:SS counter that lived in the top level. It generates its own 1 Hz tick from the system clock. It counts up or down over 2 or 3 BCD fields (MM:SS or HH:MM:SS), accepts a synchronous load and clear, and raises alarm-match and countdown-zero pulses. Its outputs feed the 7-segment scan logic and the service blocks (time set, alarm set, stopwatch, alarm check).

## Interface

Parameters:
- TICK_DIV, 100_000_000, clk cycles per count step (≥2)
- FIELDS, 2, number of 8-bit BCD fields: 2 = MM:SS, 3 = HH:MM:SS
- HOUR_WRAP, 24, modulus of the top field when FIELDS=3 (≤99); ignored when FIELDS=2

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous, active-low reset
- en  in  1  count enable; prescaler holds while low
- down  in  1  0 = count up, 1 = count down
- clear  in  1  synchronous clear of time and prescaler
- load  in  1  synchronous load of load_value
- load_value  in  8*FIELDS  BCD value to load; field 0 = seconds in bits [7:0]
- alarm_en  in  1  enables alarm compare
- alarm_value  in  8*FIELDS  BCD alarm time
- time_out  out  8*FIELDS  current BCD time, registered
- tick  out  1  one-cycle pulse per count step
- alarm_hit  out  1  one-cycle pulse on alarm match
- zero_hit  out  1  one-cycle pulse when a down-count reaches zero

## Operation

- Prescaler counts 0..TICK_DIV-1 while en=1. At TICK_DIV-1 it wraps to 0 and a step occurs.
- Field moduli: seconds and minutes 60; hours HOUR_WRAP. Each field holds two BCD digits and the low digit wraps 9→0 with a carry.
- Up step: increment seconds and ripple the carry. All fields at max wrap to all-zero (59:59→00:00; 23:59:59→00:00:00).
- Down step: decrement with borrow (10:00→09:59). At all-zero the value holds and no borrow wraps.
- Priority when several events coincide: resetn > clear > load > step.
- clear or load also resets the prescaler to 0, so the next step comes a full TICK_DIV cycles later.
- Load validation is per field. A field with any digit >9, or a value ≥ its modulus, loads as 00. Other fields load unchanged.
- alarm_hit fires only when a step makes time_out equal alarm_value while alarm_en=1. Load, clear and reset never fire it.
- zero_hit fires only when a down step moves time_out from non-zero to zero. Steps while already at zero produce no pulse.
- tick pulses on every step, including down steps that hold at zero.
- down may change at any cycle and takes effect on the next step.

## Timing

- Reset values: time_out=0, tick=0, alarm_hit=0, zero_hit=0, prescaler=0. All take effect immediately on resetn low.
- Step at clock edge E: time_out takes its new value at E. tick, alarm_hit and zero_hit are all high for exactly the cycle after E.
- After en rises, or after clear/load, the first step occurs on the TICK_DIV-th enabled edge.
- clear/load: time_out is updated at the edge that samples them (one-cycle latency). No pulses are generated.
- resetn deasserted mid-count: counting restarts from 00:00 with the prescaler at 0.
- Compare logic is derived from the next-state value and registered, so it adds no latency beyond E.

## Test plan

- TICK_DIV=4, FIELDS=2. Release reset and set en=1, down=0 -> time_out=0x0000 and outputs 0 during reset. tick pulses every 4 cycles; first step gives 0x0001.
- Wrap behaviour: load 0x0959, one step -> 0x1000. Load 0x5959, one step -> 0x0000.
- FIELDS=3, HOUR_WRAP=24: load 0x235959, one step -> 0x000000. Load 0x245959 -> 0x005959.
- Down count: load 0x0002 with down=1 -> steps give 0x0001, then 0x0000 with one zero_hit pulse. Two more steps keep 0x0000 with tick but no zero_hit.
- Alarm: alarm_en=1, alarm_value=0x0003, count up from 0 -> single alarm_hit after the third step. Loading 0x0003 directly -> no alarm_hit.
- Invalid load 0x6A12 -> 0x0012. clear and load in the same cycle -> 0x0000. resetn pulsed low mid-count -> immediate 0x0000, and the next step comes 4 enabled cycles after release.
